// File: rtl/univ_shift_reg_seq_if.sv
// Command/data bundle of the universal shift register: start/mode/amt/din and
// serial inputs in, register contents, serial outputs and busy/done status out.
interface univ_shift_reg_seq_if #(
    parameter int N  = 8,
    parameter int AW = 3
);
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [N-1:0]  din;
    logic          sin_r;
    logic          sin_l;
    logic [N-1:0]  q;
    logic          sout_r;
    logic          sout_l;
    logic          busy;
    logic          done;

    modport master (
        output start, mode, amt, din, sin_r, sin_l,
        input  q, sout_r, sout_l, busy, done
    );

    modport slave (
        input  start, mode, amt, din, sin_r, sin_l,
        output q, sout_r, sout_l, busy, done
    );
endinterface

// File: rtl/univ_shift_reg_seq.sv
// Universal shift register: parallel load, logical/arithmetic shifts and rotates,
// multi-step commands executed one bit per clock with a start/busy/done handshake.
module univ_shift_reg_seq #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic                clk,
    input  logic                reset,
    univ_shift_reg_seq_if.slave bus
);
    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SRL  = 3'b010,
        OP_SLL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_SRA  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e        state, state_nxt;
    op_e           op, op_nxt;
    logic [N-1:0]  q, q_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          done, done_nxt;
    op_e           cmd_op;
    logic          accept_shift;

    function automatic logic is_shift(input op_e o);
        return (o == OP_SRL) || (o == OP_SLL) || (o == OP_ROR) ||
               (o == OP_ROL) || (o == OP_SRA);
    endfunction

    // Serial inputs are passed in live so each step samples them at its own edge.
    function automatic logic [N-1:0] step(input op_e o, input logic [N-1:0] v,
                                          input logic sr, input logic sl);
        case (o)
            OP_SRL:  return {sr, v[N-1:1]};
            OP_SLL:  return {v[N-2:0], sl};
            OP_ROR:  return {v[0], v[N-1:1]};
            OP_ROL:  return {v[N-2:0], v[N-1]};
            OP_SRA:  return {v[N-1], v[N-1:1]};
            default: return v;
        endcase
    endfunction

    assign cmd_op       = op_e'(bus.mode);
    assign accept_shift = bus.start && is_shift(cmd_op) && (bus.amt != '0);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed by the combinational processes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            op    <= OP_NOP;
            q     <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            q     <= q_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_shift) state_nxt = SHIFT;
            SHIFT:   if (cnt == AW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        op_nxt   = op;
        q_nxt    = q;
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    op_nxt = cmd_op;
                    if (cmd_op == OP_LOAD) begin
                        q_nxt    = bus.din;
                        done_nxt = 1'b1;
                    end else if (accept_shift) begin
                        cnt_nxt = bus.amt;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            SHIFT: begin
                q_nxt    = step(op, q, bus.sin_r, bus.sin_l);
                cnt_nxt  = cnt - AW'(1);
                done_nxt = (cnt == AW'(1));
            end
            default: ;
        endcase
    end

    assign bus.q      = q;
    assign bus.sout_r = q[0];
    assign bus.sout_l = q[N-1];
    assign bus.busy   = (state == SHIFT);
    assign bus.done   = done;
endmodule
